shr_iter: RTL and testbench

- Parametrised, multi-cycle, iterative successor to the combinational right shifter.
- Accepts an operand, shift amount and mode through a valid/ready handshake.
- Shifts by up to STEP bit positions per clock, then holds the result on a valid/ready output port.
- Serves datapath units that trade latency for area, and adds arithmetic, left and rotate modes.

---
 rtl/shr_iter.sv | 220 ++++++++++++++++++++++
 tb/tb_shr_iter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shr_iter.sv
// -----------------------------------------------------------------------------
// shr_iter -- iterative multi-mode shifter
//
// Purpose:
//   Takes an operand, a shift amount and a mode through a valid/ready input
//   port. It then shifts a working copy of the operand by at most STEP bit
//   positions per clock. The final value is held on a valid/ready output port.
//   Modes: 00 logical right, 01 arithmetic right, 10 logical left,
//   11 rotate right.
//
// Parameters:
//   DATAWIDTH  operand/result width (>= 2)
//   STEP       maximum bit positions shifted per clock (1..DATAWIDTH)
//
// Ports:
//   Clk        clock, rising edge
//   Rst_n      asynchronous active-low reset
//   a          operand
//   sh_amt     unsigned shift amount
//   mode       shift mode (see above)
//   in_valid   a/sh_amt/mode valid
//   in_ready   block can accept a new operation (IDLE)
//   d          result, changes only on entry to DONE
//   out_valid  d valid (DONE)
//   out_ready  consumer accepts d
//   sticky     OR of all bits shifted out, valid with d
//
// Build option:
//   SHR_ITER_STICKY_EN  when defined, sticky accumulates shifted-out bits;
//                       otherwise sticky is tied to 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Inputs are sampled only on that edge. out_valid stays high and d
// and sticky stay stable until out_ready is seen high at an edge. A new
// operation is never accepted in the same cycle that a result is released.
// -----------------------------------------------------------------------------
module shr_iter #(
   parameter int DATAWIDTH = 8,
   parameter int STEP      = 1
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   input  logic [1:0]           mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATAWIDTH-1:0] d,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sticky
);

   localparam int RW = $clog2(DATAWIDTH + 1);
   localparam logic [RW-1:0]        DW_C   = RW'(DATAWIDTH);
   localparam logic [RW-1:0]        STEP_C = RW'(STEP);
   localparam logic [DATAWIDTH-1:0] DW_W   = DATAWIDTH'(DATAWIDTH);
   localparam logic [DATAWIDTH-1:0] ONES   = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DATAWIDTH-1:0] work_q, work_d;
   logic [RW-1:0]        rem_q, rem_d;
   logic [1:0]           mode_q, mode_d;
   logic                 sign_q, sign_d;
   logic [DATAWIDTH-1:0] d_q, d_d;

   logic [RW-1:0]        eff_amt;
   logic [RW-1:0]        step_k;
   logic [DATAWIDTH-1:0] hi_mask;
   logic [DATAWIDTH-1:0] shifted;

   // Effective amount: a rotate wraps modulo the width. Every other mode
   // saturates at the width, which already clears or sign-fills the operand.
   always_comb begin
      eff_amt = '0;
      if (mode == 2'b11) begin
         eff_amt = RW'(sh_amt % DW_W);
      end else if (sh_amt >= DW_W) begin
         eff_amt = DW_C;
      end else begin
         eff_amt = sh_amt[RW-1:0];
      end
   end

   // One shift step of k = min(STEP, rem) positions in the captured mode.
   always_comb begin
      step_k  = (rem_q < STEP_C) ? rem_q : STEP_C;
      hi_mask = ~(ONES >> step_k);
      shifted = work_q;
      case (mode_q)
         2'b00:   shifted = work_q >> step_k;
         2'b01:   shifted = (work_q >> step_k) | (sign_q ? hi_mask : '0);
         2'b10:   shifted = work_q << step_k;
         default: shifted = (work_q >> step_k) | (work_q << (DW_C - step_k));
      endcase
   end

   // Next-state and output logic.
   // A zero-amount operation still goes through one SHIFT cycle with k=0.
   // That cycle gives it the same minimum one-clock latency as a one-bit shift
   // and passes the operand through unchanged.
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      rem_d     = rem_q;
      mode_d    = mode_q;
      sign_d    = sign_q;
      d_d       = d_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_d  = a;
               mode_d  = mode;
               sign_d  = a[DATAWIDTH-1];
               rem_d   = eff_amt;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            work_d = shifted;
            rem_d  = rem_q - step_k;
            if (rem_q == step_k) begin
               d_d     = shifted;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         work_q <= '0;
         rem_q  <= '0;
         mode_q <= 2'b00;
         sign_q <= 1'b0;
         d_q    <= '0;
      end else begin
         work_q <= work_d;
         rem_q  <= rem_d;
         mode_q <= mode_d;
         sign_q <= sign_d;
         d_q    <= d_d;
      end
   end

   assign d = d_q;

`ifdef SHR_ITER_STICKY_EN
   logic [DATAWIDTH-1:0] lo_mask;
   logic                 out_bits;
   logic                 st_accept, st_finish;
   logic                 acc_q, acc_d;
   logic                 sticky_q, sticky_d;

   // acc_q collects the bits lost during the operation. sticky_q is published
   // together with d on entry to DONE.
   always_comb begin
      lo_mask   = ~(ONES << step_k);
      st_accept = (state_q == ST_IDLE) && in_valid;
      st_finish = (state_q == ST_SHIFT) && (rem_q == step_k);
      case (mode_q)
         2'b10:   out_bits = |(work_q & hi_mask);
         2'b11:   out_bits = 1'b0;
         default: out_bits = |(work_q & lo_mask);
      endcase
      acc_d    = acc_q;
      sticky_d = sticky_q;
      if (st_accept) begin
         acc_d    = 1'b0;
         sticky_d = 1'b0;
      end else if (state_q == ST_SHIFT) begin
         acc_d = acc_q | out_bits;
         if (st_finish) begin
            sticky_d = acc_q | out_bits;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         acc_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         sticky_q <= sticky_d;
      end
   end

   assign sticky = sticky_q;
`else
   assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shr_iter.sv
// -----------------------------------------------------------------------------
// tb_shr_iter -- bench for shr_iter
//
// Two DUTs share a clock and a reset: index 0 uses STEP=1 and index 1 uses
// STEP=4, both with DATAWIDTH=8. Expected results come from an integer
// arithmetic model of each shift mode and are queued at accept time.
// -----------------------------------------------------------------------------
module tb_shr_iter;

   logic       Clk;
   logic       Rst_n;
   logic [7:0] a_s    [2];
   logic [7:0] amt_s  [2];
   logic [1:0] mode_s [2];
   logic       iv_s   [2];
   logic       or_s   [2];
   logic       ir_w   [2];
   logic       ov_w   [2];
   logic       st_w   [2];
   logic [7:0] d_w    [2];

   logic [8:0] exp_q[$];
   int total;
   int bad;

   // ---------------- clock / reset ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   shr_iter #(.DATAWIDTH(8), .STEP(1)) u_step1 (
      .Clk(Clk), .Rst_n(Rst_n), .a(a_s[0]), .sh_amt(amt_s[0]), .mode(mode_s[0]),
      .in_valid(iv_s[0]), .in_ready(ir_w[0]), .d(d_w[0]), .out_valid(ov_w[0]),
      .out_ready(or_s[0]), .sticky(st_w[0])
   );

   shr_iter #(.DATAWIDTH(8), .STEP(4)) u_step4 (
      .Clk(Clk), .Rst_n(Rst_n), .a(a_s[1]), .sh_amt(amt_s[1]), .mode(mode_s[1]),
      .in_valid(iv_s[1]), .in_ready(ir_w[1]), .d(d_w[1]), .out_valid(ov_w[1]),
      .out_ready(or_s[1]), .sticky(st_w[1])
   );

   // ---------------- reference model ----------------
   function automatic int ref_eff(input logic [7:0] amt, input logic [1:0] md);
      if (md == 2'b11) return int'(amt) % 8;
      return (int'(amt) > 8) ? 8 : int'(amt);
   endfunction

   function automatic int ref_latency(input logic [7:0] amt, input logic [1:0] md,
                                      input int step);
      int e;
      e = ref_eff(amt, md);
      if (e == 0) return 1;
      return (e + step - 1) / step;
   endfunction

   // Returns {sticky, d}.
   function automatic logic [8:0] ref_result(input logic [7:0] av, input logic [7:0] amt,
                                             input logic [1:0] md);
      int e, x, sx, dv;
      logic st;
      e  = ref_eff(amt, md);
      x  = int'(av);
      st = 1'b0;
      case (md)
         2'b00: begin
            dv = x >> e;
            st = (x % (1 << e)) != 0;
         end
         2'b01: begin
            sx = av[7] ? x - 256 : x;
            dv = sx >>> e;
            st = (x % (1 << e)) != 0;
         end
         2'b10: begin
            dv = x << e;
            st = (x >> (8 - e)) != 0;
         end
         default: begin
            dv = ((x << 8) | x) >> e;
            st = 1'b0;
         end
      endcase
`ifndef SHR_ITER_STICKY_EN
      st = 1'b0;
`endif
      return {st, dv[7:0]};
   endfunction

   // ---------------- driver ----------------
   // Runs one operation on unit u. Inputs are scrambled after the accept edge,
   // and in_valid is pulsed while the unit is busy. bp is the number of DONE
   // clocks with out_ready low before the result is taken.
   task automatic run_op(input int u, input logic [7:0] av, input logic [7:0] amt,
                         input logic [1:0] md, input int bp, input string nm);
      logic [8:0] exp;
      int         exp_lat;
      int         lat;
      bit         seen;
      exp_lat = ref_latency(amt, md, (u == 0) ? 1 : 4);
      @(negedge Clk);
      a_s[u] = av; amt_s[u] = amt; mode_s[u] = md; iv_s[u] = 1'b1; or_s[u] = 1'b0;
      total++;
      if (ir_w[u] !== 1'b1) begin
         bad++;
         $display("FAIL %s ready_before_accept: got %b want 1", nm, ir_w[u]);
      end
      exp_q.push_back(ref_result(av, amt, md));
      @(posedge Clk); #1;
      iv_s[u] = 1'b0;
      a_s[u] = 8'($urandom); amt_s[u] = 8'($urandom); mode_s[u] = 2'($urandom);
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge Clk); #1;
         lat++;
         if (ov_w[u] === 1'b1) begin
            seen = 1'b1;
            iv_s[u] = 1'b0;
         end else begin
            total++;
            if (ir_w[u] !== 1'b0) begin
               bad++;
               $display("FAIL %s busy_ready: got %b want 0 at cycle %0d", nm, ir_w[u], lat);
            end
            iv_s[u] = 1'($urandom_range(0, 1));
         end
      end
      iv_s[u] = 1'b0;
      total++;
      if (!seen || lat != exp_lat) begin
         bad++;
         $display("FAIL %s latency: got %0d (seen=%0b) want %0d", nm, lat, seen, exp_lat);
      end
      exp = exp_q.pop_front();
      total++;
      if (d_w[u] !== exp[7:0]) begin
         bad++;
         $display("FAIL %s d: got %h want %h", nm, d_w[u], exp[7:0]);
      end
      total++;
      if (st_w[u] !== exp[8]) begin
         bad++;
         $display("FAIL %s sticky: got %b want %b", nm, st_w[u], exp[8]);
      end
      for (int i = 0; i < bp; i++) begin
         iv_s[u] = 1'($urandom_range(0, 1));
         @(posedge Clk); #1;
         total++;
         if (ov_w[u] !== 1'b1 || d_w[u] !== exp[7:0] || st_w[u] !== exp[8] || ir_w[u] !== 1'b0) begin
            bad++;
            $display("FAIL %s hold: got ov=%b d=%h st=%b ir=%b want ov=1 d=%h st=%b ir=0",
                     nm, ov_w[u], d_w[u], st_w[u], ir_w[u], exp[7:0], exp[8]);
         end
      end
      iv_s[u] = 1'b0;
      or_s[u] = 1'b1;
      @(posedge Clk); #1;
      or_s[u] = 1'b0;
      total++;
      if (ov_w[u] !== 1'b0 || ir_w[u] !== 1'b1) begin
         bad++;
         $display("FAIL %s release: got ov=%b ir=%b want ov=0 ir=1", nm, ov_w[u], ir_w[u]);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      Rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         a_s[u] = '0; amt_s[u] = '0; mode_s[u] = '0; iv_s[u] = 1'b0; or_s[u] = 1'b0;
      end
      repeat (3) @(posedge Clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         total++;
         if (d_w[u] !== 8'h00 || ov_w[u] !== 1'b0 || st_w[u] !== 1'b0) begin
            bad++;
            $display("FAIL reset_state u%0d: got d=%h ov=%b st=%b want 0/0/0", u, d_w[u], ov_w[u], st_w[u]);
         end
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      for (int u = 0; u < 2; u++) begin
         total++;
         if (ir_w[u] !== 1'b1 || ov_w[u] !== 1'b0) begin
            bad++;
            $display("FAIL reset_release u%0d: got ir=%b ov=%b want 1/0", u, ir_w[u], ov_w[u]);
         end
      end
   endtask

   task automatic test_step1_vectors();
      run_op(0, 8'd20,  8'd1,   2'b00, 0, "lsr_1");
      run_op(0, 8'd20,  8'd3,   2'b00, 0, "lsr_3");
      run_op(0, 8'h94,  8'd2,   2'b01, 0, "asr_2");
      run_op(0, 8'd40,  8'd4,   2'b10, 0, "lsl_4");
      run_op(0, 8'h81,  8'd9,   2'b11, 0, "ror_9");
      run_op(0, 8'hA5,  8'd200, 2'b00, 0, "lsr_sat");
      run_op(0, 8'h85,  8'd8,   2'b01, 0, "asr_width");
      run_op(0, 8'hFF,  8'd8,   2'b10, 0, "lsl_width");
      run_op(0, 8'h3C,  8'd0,   2'b01, 0, "asr_zero");
   endtask

   task automatic test_step4_vectors();
      run_op(1, 8'hF0, 8'd7,   2'b00, 0, "s4_lsr_7");
      run_op(1, 8'h5A, 8'd0,   2'b00, 0, "s4_zero");
      run_op(1, 8'h81, 8'd255, 2'b01, 0, "s4_asr_sat");
      run_op(1, 8'h37, 8'd5,   2'b11, 0, "s4_ror_5");
      run_op(1, 8'h0F, 8'd6,   2'b10, 0, "s4_lsl_6");
   endtask

   task automatic test_backpressure();
      run_op(0, 8'hB6, 8'd3, 2'b01, 3, "bp_step1");
      run_op(1, 8'h6D, 8'd5, 2'b10, 3, "bp_step4");
   endtask

   task automatic test_sticky();
      run_op(0, 8'd20, 8'd3, 2'b00, 0, "sticky_set");
      run_op(0, 8'd20, 8'd2, 2'b00, 0, "sticky_clear");
      run_op(1, 8'hC1, 8'd3, 2'b10, 0, "sticky_left");
      run_op(1, 8'hFF, 8'd3, 2'b11, 0, "sticky_rotate");
   endtask

   task automatic test_reset_mid_shift();
      run_op(0, 8'hFF, 8'd1, 2'b00, 0, "pre_reset");
      @(negedge Clk);
      a_s[0] = 8'hC3; amt_s[0] = 8'd6; mode_s[0] = 2'b00; iv_s[0] = 1'b1;
      @(posedge Clk); #1;
      iv_s[0] = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b0;
      #1;
      total++;
      if (d_w[0] !== 8'h00 || ov_w[0] !== 1'b0 || st_w[0] !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_immediate: got d=%h ov=%b st=%b want 0/0/0", d_w[0], ov_w[0], st_w[0]);
      end
      repeat (3) begin
         @(posedge Clk); #1;
         total++;
         if (ov_w[0] !== 1'b0 || d_w[0] !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_hold: got ov=%b d=%h want 0/00", ov_w[0], d_w[0]);
         end
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (8) begin
         @(posedge Clk); #1;
         total++;
         if (ov_w[0] !== 1'b0 || ir_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_after: got ov=%b ir=%b want 0/1", ov_w[0], ir_w[0]);
         end
      end
      run_op(0, 8'h94, 8'd2, 2'b01, 0, "post_reset");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         run_op(0, 8'($urandom), 8'($urandom_range(0, 9)), 2'($urandom), 0, "b2b_step1");
         run_op(1, 8'($urandom), 8'($urandom_range(0, 9)), 2'($urandom), 0, "b2b_step4");
      end
   endtask

   task automatic test_random();
      logic [7:0] amt;
      for (int i = 0; i < 40; i++) begin
         amt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
         run_op(i % 2, 8'($urandom), amt, 2'($urandom), $urandom_range(0, 2), "random");
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_step1_vectors();
      test_step4_vectors();
      test_backpressure();
      test_sticky();
      test_reset_mid_shift();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
